seq_mag_comparator: RTL and testbench
=====================================

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..64).
REQ-002 SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a compare.
REQ-006 SHALL have port A  input  WIDTH  first operand.
REQ-007 SHALL have port B  input  WIDTH  second operand.
REQ-008 SHALL have port busy  output  1  high while a compare is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result valid and updated.
REQ-010 SHALL have port E  output  1  result A == B.
REQ-011 SHALL have port G  output  1  result A > B.
REQ-012 SHALL have port L  output  1  result A < B.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL accept start when busy==0 (IDLE or DONE): capture A and B, load bit index WIDTH-1, go to RUN.
REQ-015 SHALL ignore start while in RUN; captured operands SHALL NOT change.
REQ-016 SHALL examine one bit per RUN cycle, MSB first, index decrementing.
REQ-017 SHALL, at the first differing bit, record G=A[i]&~B[i] and L=~A[i]&B[i]; when SIGNED=1 and i==WIDTH-1, G and L SHALL be swapped.
REQ-018 SHALL go to DONE after index 0 is examined, or earlier per REQ-027; with no differing bit, the result SHALL be E=1.
REQ-019 SHALL update E/G/L only on the edge entering DONE; the outputs SHALL hold until the next completion.
REQ-020 SHALL keep E/G/L exactly one-hot after the first completion.
REQ-021 SHALL assert done only in DONE, for exactly one cycle; busy SHALL be 1 only in RUN.
REQ-022 SHALL go from DONE to RUN if start==1, else to IDLE, so back-to-back compares lose no cycle.
REQ-023 SHALL, for WIDTH=1, take exactly one RUN cycle.

Reset
REQ-024 SHALL, on any clk edge with rst_n==0 in any state (including mid-RUN), enter IDLE with busy=0, done=0, E=0, G=0, L=0, and clear the index and operand registers.
REQ-025 SHALL discard an in-progress compare on reset, with no done pulse.
REQ-026 SHALL give rst_n priority over start on the same edge.

Configuration
REQ-027 SHALL, with macro SEQ_CMP_EARLY_EXIT_EN defined, leave RUN on the cycle the first differing bit is examined (latency 1..WIDTH RUN cycles).
REQ-028 SHALL, without SEQ_CMP_EARLY_EXIT_EN, always spend exactly WIDTH RUN cycles, retaining the first difference and ignoring later bits.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the result-encoding constants in shared package cmp_pkg.
REQ-030 SHALL implement the per-bit step (prior eq/gt/lt, A bit, B bit, MSB/signed flag -> next eq/gt/lt) as combinational sub-module cmp_bit_cell, instantiated once.
REQ-031 SHALL size the index counter to $clog2(WIDTH), minimum 1 bit.

Verification
REQ-032 SHALL cover, WIDTH=8, rst_n low 2 cycles during the 3rd RUN cycle -> busy=0, done never pulses, E=G=L=0, next start works normally.
REQ-033 SHALL cover, WIDTH=8, SIGNED=0, A=8'h5A, B=8'h5A -> E=1; done pulses 8 RUN cycles after acceptance, with or without the macro.
REQ-034 SHALL cover, WIDTH=8, SIGNED=0, A=8'h80, B=8'h7F -> G=1; done after 1 RUN cycle with SEQ_CMP_EARLY_EXIT_EN, after 8 without.
REQ-035 SHALL cover, WIDTH=8, SIGNED=1, A=8'h80, B=8'h7F -> L=1; and A=8'hFF, B=8'hFE -> G=1.
REQ-036 SHALL cover start held high through RUN with operands changed to A=8'h00, B=8'hFF -> first result unaffected; start high in DONE cycle accepted immediately, giving L=1 on the second done.
REQ-037 SHALL cover, WIDTH=1, all four (A,B) combinations back-to-back -> (0,0) E, (0,1) L, (1,0) G, (1,1) E, each after one RUN cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // Running compare verdict; exactly one bit set once a compare has finished.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = 3'b000;
  localparam cmp_res_t RES_EQ   = 3'b100;
  localparam cmp_res_t RES_GT   = 3'b010;
  localparam cmp_res_t RES_LT   = 3'b001;

endpackage

// File: rtl/cmp_bit_cell.sv
// One MSB-first compare step: folds a single A/B bit pair into the running verdict.
module cmp_bit_cell
  import cmp_pkg::*;
(
  input  cmp_res_t prior_i,
  input  logic     a_bit_i,
  input  logic     b_bit_i,
  input  logic     msb_signed_i,
  output cmp_res_t next_o
);

  // Only the first differing bit decides; a set sign bit means the smaller value.
  always_comb begin
    next_o = prior_i;
    if (prior_i.eq && (a_bit_i != b_bit_i)) begin
      if (a_bit_i ^ msb_signed_i) begin
        next_o = RES_GT;
      end else begin
        next_o = RES_LT;
      end
    end
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Bit-serial magnitude comparator, one bit per cycle MSB first.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             G,
  output logic             L
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  cmp_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  cmp_res_t         run_q, run_d;
  cmp_res_t         res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  cmp_res_t         cell_res_c;
  logic             msb_signed_c;
  logic             exit_early_c;

  assign msb_signed_c = SIGNED && (idx_q == IDX_MSB);

  cmp_bit_cell u_cell (
    .prior_i      (run_q),
    .a_bit_i      (a_q[idx_q]),
    .b_bit_i      (b_q[idx_q]),
    .msb_signed_i (msb_signed_c),
    .next_o       (cell_res_c)
  );

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign exit_early_c = ~cell_res_c.eq;
`else
  assign exit_early_c = 1'b0;
`endif

  // State and datapath registers; reset also wipes operands and index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      run_q   <= RES_NONE;
      res_q   <= RES_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      run_q   <= run_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic; published result changes only when entering DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    run_d   = run_q;
    res_d   = res_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IDX_MSB;
          run_d   = RES_EQ;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        run_d  = cell_res_c;
        idx_d  = idx_q - IW'(1);
        busy_d = 1'b1;
        if ((idx_q == '0) || exit_early_c) begin
          res_d   = cell_res_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign E    = res_q.eq;
  assign G    = res_q.gt;
  assign L    = res_q.lt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench: unsigned/signed 8-bit comparators and a 1-bit comparator.
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       u_start, s_start, w_start;
  logic [7:0] u_a, u_b, s_a, s_b;
  logic       w_a, w_b;
  logic       u_busy, u_done, u_e, u_g, u_l;
  logic       s_busy, s_done, s_e, s_g, s_l;
  logic       w_busy, w_done, w_e, w_g, w_l;

  int total = 0;
  int bad   = 0;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  seq_mag_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(u_start), .A(u_a), .B(u_b),
    .busy(u_busy), .done(u_done), .E(u_e), .G(u_g), .L(u_l)
  );

  seq_mag_comparator #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .A(s_a), .B(s_b),
    .busy(s_busy), .done(s_done), .E(s_e), .G(s_g), .L(s_l)
  );

  seq_mag_comparator #(.WIDTH(1), .SIGNED(1'b0)) w_dut (
    .clk(clk), .rst_n(rst_n), .start(w_start), .A(w_a), .B(w_b),
    .busy(w_busy), .done(w_done), .E(w_e), .G(w_g), .L(w_l)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit compare, then count RUN cycles until done (bounded).
  task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic [2:0] res, output bit busy_ok);
    if (sgn) begin s_a = a; s_b = b; s_start = 1'b1; end
    else     begin u_a = a; u_b = b; u_start = 1'b1; end
    tick;
    s_start = 1'b0;
    u_start = 1'b0;
    busy_ok = sgn ? s_busy : u_busy;
    lat = 0;
    res = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick;
      lat++;
      if (sgn ? s_done : u_done) begin
        res = sgn ? {s_e, s_g, s_l} : {u_e, u_g, u_l};
        break;
      end
      if (!(sgn ? s_busy : u_busy)) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    total++;
    if ({u_busy, u_done, u_e, u_g, u_l} !== 5'b00000) begin
      bad++; $display("FAIL reset_u8 got=%b want=00000", {u_busy, u_done, u_e, u_g, u_l});
    end
    total++;
    if ({s_busy, s_done, s_e, s_g, s_l} !== 5'b00000) begin
      bad++; $display("FAIL reset_s8 got=%b want=00000", {s_busy, s_done, s_e, s_g, s_l});
    end
    total++;
    if ({w_busy, w_done, w_e, w_g, w_l} !== 5'b00000) begin
      bad++; $display("FAIL reset_w1 got=%b want=00000", {w_busy, w_done, w_e, w_g, w_l});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_equal;
    int lat; logic [2:0] res; bit bok;
    run8(1'b0, 8'h5A, 8'h5A, lat, res, bok);
    total++;
    if (res !== 3'b100) begin bad++; $display("FAIL eq_5a_res got=%b want=100", res); end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL eq_5a_lat got=%0d want=8", lat); end
    total++;
    if (bok !== 1'b1) begin bad++; $display("FAIL eq_5a_busy got=%b want=1", bok); end
    total++;
    if (u_busy !== 1'b0) begin bad++; $display("FAIL eq_5a_busy_at_done got=%b want=0", u_busy); end
  endtask

  task automatic test_unsigned;
    int lat; logic [2:0] res; bit bok;
    run8(1'b0, 8'h80, 8'h7F, lat, res, bok);
    total++;
    if (res !== 3'b010) begin bad++; $display("FAIL u_80_7f_res got=%b want=010", res); end
    total++;
    if (lat !== (EARLY ? 1 : 8)) begin
      bad++; $display("FAIL u_80_7f_lat got=%0d want=%0d", lat, EARLY ? 1 : 8);
    end
    run8(1'b0, 8'h01, 8'h02, lat, res, bok);
    total++;
    if (res !== 3'b001) begin bad++; $display("FAIL u_01_02_res got=%b want=001", res); end
    total++;
    if (lat !== (EARLY ? 7 : 8)) begin
      bad++; $display("FAIL u_01_02_lat got=%0d want=%0d", lat, EARLY ? 7 : 8);
    end
  endtask

  task automatic test_signed;
    int lat; logic [2:0] res; bit bok;
    run8(1'b1, 8'h80, 8'h7F, lat, res, bok);
    total++;
    if (res !== 3'b001) begin bad++; $display("FAIL s_80_7f_res got=%b want=001", res); end
    total++;
    if (lat !== (EARLY ? 1 : 8)) begin
      bad++; $display("FAIL s_80_7f_lat got=%0d want=%0d", lat, EARLY ? 1 : 8);
    end
    run8(1'b1, 8'hFF, 8'hFE, lat, res, bok);
    total++;
    if (res !== 3'b010) begin bad++; $display("FAIL s_ff_fe_res got=%b want=010", res); end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL s_ff_fe_lat got=%0d want=8", lat); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({s_busy, s_done, s_e, s_g, s_l} !== 5'b00010) begin
        bad++; $display("FAIL hold_s8 cyc=%0d got=%b want=00010", i, {s_busy, s_done, s_e, s_g, s_l});
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit seen;
    u_a = 8'hC3; u_b = 8'h3C; u_start = 1'b1;
    tick;
    u_a = 8'h00; u_b = 8'hFF;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick; lat++;
      if (u_done) seen = 1'b1;
    end
    total++;
    if ({seen, u_e, u_g, u_l} !== 4'b1010) begin
      bad++; $display("FAIL b2b_first_res got=%b want=1010", {seen, u_e, u_g, u_l});
    end
    total++;
    if (lat !== (EARLY ? 1 : 8)) begin
      bad++; $display("FAIL b2b_first_lat got=%0d want=%0d", lat, EARLY ? 1 : 8);
    end
    tick;
    u_start = 1'b0;
    total++;
    if ({u_busy, u_done} !== 2'b10) begin
      bad++; $display("FAIL b2b_accept got=%b want=10", {u_busy, u_done});
    end
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick; lat++;
      if (u_done) seen = 1'b1;
    end
    total++;
    if ({seen, u_e, u_g, u_l} !== 4'b1001) begin
      bad++; $display("FAIL b2b_second_res got=%b want=1001", {seen, u_e, u_g, u_l});
    end
    total++;
    if (lat !== (EARLY ? 1 : 8)) begin
      bad++; $display("FAIL b2b_second_lat got=%0d want=%0d", lat, EARLY ? 1 : 8);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat; logic [2:0] res; bit bok;
    bit quiet;
    u_a = 8'h5A; u_b = 8'h5A; u_start = 1'b1;
    tick;
    u_start = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if ({u_busy, u_done, u_e, u_g, u_l} !== 5'b00000) begin
        bad++; $display("FAIL midrun_reset cyc=%0d got=%b want=00000", i, {u_busy, u_done, u_e, u_g, u_l});
      end
    end
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (u_done || u_busy) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("FAIL midrun_no_done got=%b want=1", quiet); end
    run8(1'b0, 8'h01, 8'h02, lat, res, bok);
    total++;
    if (res !== 3'b001) begin bad++; $display("FAIL midrun_after_res got=%b want=001", res); end
    total++;
    if (lat !== (EARLY ? 7 : 8)) begin
      bad++; $display("FAIL midrun_after_lat got=%0d want=%0d", lat, EARLY ? 7 : 8);
    end
  endtask

  task automatic test_width1;
    logic [3:0] pa;
    logic [3:0] pb;
    logic [2:0] w_exp [4];
    pa = 4'b1100;
    pb = 4'b1010;
    w_exp[0] = 3'b100;
    w_exp[1] = 3'b001;
    w_exp[2] = 3'b010;
    w_exp[3] = 3'b100;
    w_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w_a = pa[k];
      w_b = pb[k];
      tick;
      total++;
      if ({w_busy, w_done} !== 2'b10) begin
        bad++; $display("FAIL w1_run k=%0d got=%b want=10", k, {w_busy, w_done});
      end
      tick;
      total++;
      if ({w_done, w_e, w_g, w_l} !== {1'b1, w_exp[k]}) begin
        bad++; $display("FAIL w1_res k=%0d got=%b want=%b", k, {w_done, w_e, w_g, w_l}, {1'b1, w_exp[k]});
      end
    end
    w_start = 1'b0;
    tick;
    total++;
    if ({w_busy, w_done, w_e} !== 3'b001) begin
      bad++; $display("FAIL w1_idle got=%b want=001", {w_busy, w_done, w_e});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    u_start = 1'b0; s_start = 1'b0; w_start = 1'b0;
    u_a = '0; u_b = '0; s_a = '0; s_b = '0; w_a = 1'b0; w_b = 1'b0;
    test_reset;
    test_equal;
    test_unsigned;
    test_signed;
    test_hold;
    test_back_to_back;
    test_reset_mid_run;
    test_width1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
